ifetch: RTL and testbench

Instruction fetch stage between the fetch port of the memory controller and the decoder. Serves one halfword-aligned fetch address per cycle from a direct-mapped instruction cache and returns the 32-bit parcel starting at that address. On a miss it requests 4 bytes from the memory controller, fills the cache, then presents the parcel. It flags RV32C instructions and drops stale work when a flush is requested.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/icache_array.sv | 42 ++++
 rtl/ifetch.sv | 114 +++++++++++
 tb/tb_ifetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch stage and its cache array.
package ifetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MISS  = 2'd1,
      S_ABORT = 2'd2
   } fetch_state_t;

   localparam int IDX_W_DEF = 6;

   // Tag covers addr[31:IDX_W+1]; bit 0 never participates.
   function automatic int tag_w(input int idx_w);
      return 31 - idx_w;
   endfunction

   function automatic logic is_c_f(input logic [1:0] lo);
      return lo != 2'b11;
   endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: combinational read, synchronous write,
// asynchronous clear of all valid bits.
module icache_array
   import ifetch_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   localparam int TAG_W = tag_w(IDX_W),
   localparam int NENT  = 1 << IDX_W
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [IDX_W-1:0] i_rd_idx,
   input  logic [TAG_W-1:0] i_rd_tag,
   output logic             o_hit,
   output logic [31:0]      o_rd_data,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic [31:0]      i_wr_data
);

   logic [NENT-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [NENT];
   logic [31:0]      r_data [NENT];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   r_valid           <= '0;
      else if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
   end

   // Tag/data need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk_in) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
   assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage with optional direct-mapped I-cache.
// Define ICACHE_EN to build the cache; otherwise every lookup misses.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_enable,
   input  logic [31:0] if_addr,
   output logic        inst_ready,
   output logic        is_c,
   output logic [31:0] inst_val,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic        ic_done,
   input  logic [31:0] ic_data
);

   fetch_state_t r_state;
   logic         r_inst_ready;
   logic         r_is_c;
   logic [31:0]  r_inst_val;
   logic         r_ic_req;
   logic [31:0]  r_ic_addr;

   logic         w_hit;
   logic [31:0]  w_rd_data;
   logic [31:0]  w_addr;
   logic         w_unused;

   assign w_addr   = {if_addr[31:1], 1'b0};
   assign w_unused = if_addr[0];

`ifdef ICACHE_EN
   logic w_wr_en;
   // Fills land in both MISS and ABORT so a flushed fetch still warms the cache.
   assign w_wr_en = rdy_in && ic_done && (r_state != S_IDLE);

   icache_array #(.IDX_W(IDX_W)) u_icache (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .i_rd_idx  (if_addr[IDX_W:1]),
      .i_rd_tag  (if_addr[31:IDX_W+1]),
      .o_hit     (w_hit),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (r_ic_addr[IDX_W:1]),
      .i_wr_tag  (r_ic_addr[31:IDX_W+1]),
      .i_wr_data (ic_data)
   );
`else
   assign w_hit     = 1'b0;
   assign w_rd_data = '0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= S_IDLE;
         r_inst_ready <= 1'b0;
         r_is_c       <= 1'b0;
         r_inst_val   <= '0;
         r_ic_req     <= 1'b0;
         r_ic_addr    <= '0;
      end else if (rdy_in) begin
         r_inst_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (if_enable && !clear) begin
                  if (w_hit) begin
                     r_inst_val   <= w_rd_data;
                     r_is_c       <= is_c_f(w_rd_data[1:0]);
                     r_inst_ready <= 1'b1;
                  end else begin
                     r_ic_addr <= w_addr;
                     r_ic_req  <= 1'b1;
                     r_state   <= S_MISS;
                  end
               end
            end
            S_MISS: begin
               if (ic_done) begin
                  r_ic_req <= 1'b0;
                  r_state  <= S_IDLE;
                  if (!clear) begin
                     r_inst_val   <= ic_data;
                     r_is_c       <= is_c_f(ic_data[1:0]);
                     r_inst_ready <= 1'b1;
                  end
               end else if (clear) begin
                  r_state <= S_ABORT;
               end
            end
            S_ABORT: begin
               if (ic_done) begin
                  r_ic_req <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign inst_ready = r_inst_ready;
   assign is_c       = r_is_c;
   assign inst_val   = r_inst_val;
   assign ic_req     = r_ic_req;
   assign ic_addr    = r_ic_addr;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: directed fetches push expected parcels, a monitor pops on inst_ready.
module tb_ifetch;

`ifdef ICACHE_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        clear = 1'b0;
   logic        if_enable = 1'b0;
   logic [31:0] if_addr = '0;
   logic        inst_ready;
   logic        is_c;
   logic [31:0] inst_val;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_done = 1'b0;
   logic [31:0] ic_data = '0;

   typedef struct packed {
      logic [31:0] val;
      logic        isc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   ifetch #(.IDX_W(6)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .clear      (clear),
      .if_enable  (if_enable),
      .if_addr    (if_addr),
      .inst_ready (inst_ready),
      .is_c       (is_c),
      .inst_val   (inst_val),
      .ic_req     (ic_req),
      .ic_addr    (ic_addr),
      .ic_done    (ic_done),
      .ic_data    (ic_data)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (rst_n_in && inst_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_inst_ready: got val %h expected no pulse (t=%0t)", inst_val, $time);
         end else begin
            e = sb.pop_front();
            chk("inst_val", inst_val, e.val);
            chk("is_c", {31'd0, is_c}, {31'd0, e.isc});
         end
      end
   end

   // One fetch; cached=1 means the address should hit when the cache is built.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                        input bit cached, input int lat, input int stall);
      bit   hit;
      exp_t e;
      hit   = CE && cached;
      e.val = data;
      e.isc = (data[1:0] != 2'b11);
      @(negedge clk_in);
      if_enable = 1'b1;
      if_addr   = addr;
      sb.push_back(e);
      @(negedge clk_in);
      if_enable = 1'b0;
      chk("ic_req_after_lookup", {31'd0, ic_req}, {31'd0, !hit});
      if (!hit) begin
         chk("ic_addr", ic_addr, {addr[31:1], 1'b0});
         if (stall > 0) begin
            rdy_in = 1'b0;
            for (int i = 0; i < stall; i++) begin
               @(negedge clk_in);
               chk("ic_req_stall", {31'd0, ic_req}, 32'd1);
               chk("ic_addr_stall", ic_addr, {addr[31:1], 1'b0});
            end
            rdy_in = 1'b1;
         end
         for (int i = 1; i < lat; i++) begin
            @(negedge clk_in);
            chk("ic_req_hold", {31'd0, ic_req}, 32'd1);
         end
         ic_done = 1'b1;
         ic_data = data;
         @(negedge clk_in);
         ic_done = 1'b0;
         ic_data = '0;
         #1;
         chk("ic_req_released", {31'd0, ic_req}, 32'd0);
      end else begin
         @(negedge clk_in);
         #1;
      end
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #12;
      chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
      chk("rst_is_c", {31'd0, is_c}, 32'd0);
      chk("rst_inst_val", inst_val, 32'd0);
      chk("rst_ic_req", {31'd0, ic_req}, 32'd0);
      chk("rst_ic_addr", ic_addr, 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Cold fetch, then refetch.
      fetch(32'h0, 32'h00A00093, 1'b0, 3, 0);
      fetch(32'h0, 32'h00A00093, 1'b1, 3, 0);
      // Compressed parcel; odd address aliases onto the same halfword.
      fetch(32'h6, 32'h00004505, 1'b0, 2, 0);
      fetch(32'h7, 32'h00004505, 1'b1, 2, 0);
      // Conflict eviction: 0x80 shares index 0 with 0x0.
      fetch(32'h80, 32'hDEADBEEF, 1'b0, 1, 0);
      fetch(32'h0, 32'h00A00093, 1'b0, 2, 0);
      fetch(32'h80, 32'hDEADBEEF, 1'b0, 1, 0);
      // Overlapping neighbour at +2 is a separate entry.
      fetch(32'h2, 32'h12345678, 1'b0, 1, 0);

      // Clear in MISS, fill arrives 2 cycles later, nothing presented.
      @(negedge clk_in);
      if_enable = 1'b1;
      if_addr   = 32'h40;
      @(negedge clk_in);
      if_enable = 1'b0;
      clear     = 1'b1;
      chk("clr_ic_req", {31'd0, ic_req}, 32'd1);
      @(negedge clk_in);
      clear = 1'b0;
      chk("abort_ic_req", {31'd0, ic_req}, 32'd1);
      @(negedge clk_in);
      ic_done = 1'b1;
      ic_data = 32'hCAFE0001;
      @(negedge clk_in);
      ic_done = 1'b0;
      #1;
      chk("abort_ic_req_drop", {31'd0, ic_req}, 32'd0);
      @(negedge clk_in);
      fetch(32'h40, 32'hCAFE0001, 1'b1, 1, 0);

      // Clear coinciding with ic_done: fill but do not present.
      @(negedge clk_in);
      if_enable = 1'b1;
      if_addr   = 32'h44;
      @(negedge clk_in);
      if_enable = 1'b0;
      clear     = 1'b1;
      ic_done   = 1'b1;
      ic_data   = 32'h00008082;
      @(negedge clk_in);
      clear   = 1'b0;
      ic_done = 1'b0;
      #1;
      chk("clr_done_ic_req", {31'd0, ic_req}, 32'd0);
      @(negedge clk_in);
      fetch(32'h44, 32'h00008082, 1'b1, 1, 0);

      // Clear in IDLE suppresses the lookup.
      @(negedge clk_in);
      if_enable = 1'b1;
      clear     = 1'b1;
      if_addr   = 32'h300;
      @(negedge clk_in);
      if_enable = 1'b0;
      clear     = 1'b0;
      chk("idle_clear_no_req", {31'd0, ic_req}, 32'd0);

      // rdy_in low for 4 cycles mid-miss.
      fetch(32'h100, 32'h00B50533, 1'b0, 2, 4);

      // Reset mid-miss drops the request and invalidates the cache.
      @(negedge clk_in);
      if_enable = 1'b1;
      if_addr   = 32'h200;
      @(negedge clk_in);
      if_enable = 1'b0;
      chk("pre_rst_ic_req", {31'd0, ic_req}, 32'd1);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("async_rst_ic_req", {31'd0, ic_req}, 32'd0);
      chk("async_rst_ic_addr", ic_addr, 32'd0);
      chk("async_rst_inst_val", inst_val, 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      fetch(32'h100, 32'h00B50533, 1'b0, 1, 0);

      repeat (3) @(negedge clk_in);
      chk("sb_final_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
